pixel_writer: RTL and testbench
===============================

Name: pixel_writer

Overview:
- Write-side counterpart to the TFT pixel reader.
- Accepts RGB888 pixels from an upstream source (video capture or test generator) over a rdy/stb handshake.
- Packs each pixel into a 24-bit word and streams it into a two-channel ping-pong FIFO write port.
- Per buffer: acquires a ready channel, fills it to its reported size, then releases it. Buffers are also released early on end-of-line/frame or an idle timeout.

Parameters:
- FLUSH_TIMEOUT, 256: idle cycles with a partially filled buffer before forced release; 0 disables the timeout.
- TIMEOUT_WIDTH, 16: width of the idle counter; FLUSH_TIMEOUT must be < 2^TIMEOUT_WIDTH.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  allow acquisition of new buffers
- i_red  in  8  pixel red
- i_green  in  8  pixel green
- i_blue  in  8  pixel blue
- i_pixel_last  in  1  qualifies with i_pixel_stb; last pixel of line/frame
- i_pixel_stb  in  1  upstream offers pixel
- o_pixel_rdy  out  1  block can accept a pixel this cycle
- i_write_rdy  in  2  per-channel FIFO buffer available
- o_write_act  out  2  per-channel activate, one-hot or zero
- i_write_size  in  24  capacity of the buffer being activated
- o_write_stb  out  1  write strobe, one word per cycle
- o_write_data  out  24  {red, green, blue}
- o_busy  out  1  high while any channel is active

Behaviour:
Reset:
- Asynchronous on rst_n low.
- o_write_act=0, o_write_stb=0, o_write_data=0, o_busy=0, state=IDLE, counters=0.
- o_pixel_rdy=0, since it is derived from state.
- Reset mid-buffer drops activate immediately. The partial buffer is abandoned; no further strobes are issued.

State machine:
- IDLE:
  - Transition when i_enable=1, o_write_act==0 and i_write_rdy!=0.
  - Select channel 0 if i_write_rdy[0], else channel 1.
  - Set o_write_act[ch]<=1, latch i_write_size into r_size, clear r_count and r_idle, then go to WRITE.
- WRITE:
  - o_pixel_rdy is combinational and equals (state==WRITE && r_count<r_size).
  - Accept occurs when o_pixel_rdy && i_pixel_stb.
  - On accept, the next cycle gives o_write_stb=1, o_write_data={i_red,i_green,i_blue}, r_count+1 and r_idle=0. Latency is 1 cycle from accept to strobe.
  - Go to RELEASE on any of:
    - an accept with i_pixel_last=1;
    - an accept that makes r_count+1==r_size;
    - r_size==0 (checked on the first WRITE cycle, no strobes issued);
    - FLUSH_TIMEOUT!=0 && r_count>0 && r_idle reaches FLUSH_TIMEOUT-1 with no accept that cycle.
  - Otherwise r_idle increments on non-accept cycles, but only when r_count>0.
- RELEASE:
  - o_pixel_rdy=0.
  - o_write_act stays high this cycle, so the final strobe lands while the channel is still active.
  - At the end of the cycle o_write_act<=0, then go to IDLE.
  - At least one cycle of o_write_act==0 separates consecutive buffers.

General rules:
- o_write_stb is a single-cycle pulse per accepted pixel and is never asserted while o_write_act==0.
- i_pixel_stb without o_pixel_rdy is ignored; no data is captured.
- i_write_size changes during WRITE are ignored; r_size is used.
- i_enable low does not terminate an active buffer. It only blocks the next IDLE→WRITE transition.
- If both channels are ready after a release, channel 0 wins. Strict alternation is left to the FIFO's ready sequencing.
- o_busy = |o_write_act.
- r_count width is 24 bits. Comparison is unsigned; there is no wrap because accepts stop at r_size.

Test Plan:
1. Basic fill: i_write_rdy=01, size=4, four back-to-back pixels 0x112233..0x445566 → act=01 one cycle after rdy; four strobes with matching data, each 1 cycle after accept; act drops 1 cycle after the 4th strobe; rdy low in RELEASE.
2. Ping-pong: i_write_rdy=11, size=3, six pixels streamed continuously → buffer 1 on ch0 with 3 strobes, ≥1 cycle act=00, buffer 2 on ch1 (ch0 rdy cleared by FIFO) with 3 strobes; no pixel lost or duplicated.
3. Early last: size=8, i_pixel_last on the 3rd pixel → exactly 3 strobes, then release; the next pixel waits for a new buffer.
4. Timeout flush: FLUSH_TIMEOUT=10, size=16, 2 pixels then stb idle → act drops exactly 10 cycles after the 2nd accept plus the RELEASE cycle; no timeout while r_count==0.
5. Backpressure/edge: i_write_rdy=00 with stb held → o_pixel_rdy=0 and no strobes. Then size=0 activation → act pulses with zero strobes and returns to IDLE.
6. Reset mid-buffer: assert rst_n=0 asynchronously after 2 of 4 pixels → act, stb and data go to 0 immediately without waiting for a clock edge; after release, a new buffer starts cleanly with r_count=0.

Source files
------------

// File: rtl/pixel_writer_if.sv
// Pixel-in / FIFO-write-out bundle for pixel_writer.
// The master modport is the writer itself; the slave modport is the pixel source plus FIFO side.
interface pixel_writer_if;
    logic        enable;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        pixel_last;
    logic        pixel_stb;
    logic        pixel_rdy;
    logic [1:0]  write_rdy;
    logic [1:0]  write_act;
    logic [23:0] write_size;
    logic        write_stb;
    logic [23:0] write_data;
    logic        busy;

    modport master (
        input  enable, red, green, blue, pixel_last, pixel_stb, write_rdy, write_size,
        output pixel_rdy, write_act, write_stb, write_data, busy
    );

    modport slave (
        output enable, red, green, blue, pixel_last, pixel_stb, write_rdy, write_size,
        input  pixel_rdy, write_act, write_stb, write_data, busy
    );
endinterface

// File: rtl/pixel_writer.sv
// Packs RGB888 pixels into 24-bit words and fills ping-pong FIFO buffers one at a time,
// releasing each buffer when full, on a last pixel, or after an idle timeout.
module pixel_writer #(
    parameter int unsigned FLUSH_TIMEOUT = 256,
    parameter int unsigned TIMEOUT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pixel_writer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RELEASE
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] IDLE_LIMIT =
        TIMEOUT_WIDTH'((FLUSH_TIMEOUT == 0) ? 0 : FLUSH_TIMEOUT - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] IDLE_STEP = TIMEOUT_WIDTH'(1);

    state_t                   state;
    logic [23:0]              r_size;
    logic [23:0]              r_count;
    logic [TIMEOUT_WIDTH-1:0] r_idle;
    logic [1:0]               act_q;
    logic                     stb_q;
    logic [23:0]              data_q;

    logic        pixel_rdy;
    logic        accept;
    logic        timeout_hit;
    logic [23:0] count_next;

    // Ready is a pure function of state so it drops the cycle a buffer fills or closes.
    assign pixel_rdy   = (state == WRITE) && (r_count < r_size);
    assign accept      = pixel_rdy && bus.pixel_stb;
    assign count_next  = r_count + 24'd1;
    assign timeout_hit = (FLUSH_TIMEOUT != 0) && (r_count != '0) && (r_idle == IDLE_LIMIT);

    assign bus.pixel_rdy  = pixel_rdy;
    assign bus.write_act  = act_q;
    assign bus.write_stb  = stb_q;
    assign bus.write_data = data_q;
    assign bus.busy       = |act_q;

    // NOTE: every register here updates with <= so all reads in this block see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            r_size  <= '0;
            r_count <= '0;
            r_idle  <= '0;
            act_q   <= '0;
            stb_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            stb_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable && (act_q == 2'b00) && (bus.write_rdy != 2'b00)) begin
                        act_q   <= bus.write_rdy[0] ? 2'b01 : 2'b10;
                        r_size  <= bus.write_size;
                        r_count <= '0;
                        r_idle  <= '0;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        stb_q   <= 1'b1;
                        data_q  <= {bus.red, bus.green, bus.blue};
                        r_count <= count_next;
                        r_idle  <= '0;
                        if (bus.pixel_last || (count_next == r_size)) begin
                            state <= RELEASE;
                        end
                    end else if (r_size == '0) begin
                        state <= RELEASE;
                    end else if (timeout_hit) begin
                        state <= RELEASE;
                    end else if (r_count != '0) begin
                        r_idle <= r_idle + IDLE_STEP;
                    end
                end
                RELEASE: begin
                    // Activate is held through this cycle so the final strobe lands on an active channel.
                    act_q <= '0;
                    state <= IDLE;
                end
                default: begin
                    act_q <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: directed scenarios plus random traffic,
// compared every cycle against a buffer-level behavioural model.
module tb_pixel_writer;

    localparam int T = 10;

    logic clk;
    logic rst_n;
    pixel_writer_if bus();

    pixel_writer #(
        .FLUSH_TIMEOUT (T),
        .TIMEOUT_WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Behavioural model: which channel holds the open buffer, how full it is,
    // how many consecutive idle cycles it has seen, and whether it is closing.
    int          m_ch;
    int          m_cap;
    int          m_fill;
    int          m_idle;
    bit          m_closing;
    bit          m_stb;
    logic [23:0] m_data;
    logic [25:0] log_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_ch      = -1;
        m_cap     = 0;
        m_fill    = 0;
        m_idle    = 0;
        m_closing = 1'b0;
        m_stb     = 1'b0;
        m_data    = '0;
    endtask

    always @(negedge clk) begin
        logic [1:0] exp_act;
        bit         exp_rdy;
        if (!rst_n) begin
            model_reset();
            check("rst_act", bus.write_act, 0);
            check("rst_stb", bus.write_stb, 0);
            check("rst_data", bus.write_data, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_rdy", bus.pixel_rdy, 0);
        end else begin
            exp_act = (m_ch < 0) ? 2'b00 : 2'(1 << m_ch);
            exp_rdy = (m_ch >= 0) && !m_closing && (m_fill < m_cap);
            check("act", bus.write_act, exp_act);
            check("busy", bus.busy, m_ch >= 0);
            check("pixel_rdy", bus.pixel_rdy, exp_rdy);
            check("write_stb", bus.write_stb, m_stb);
            if (m_stb) check("write_data", bus.write_data, m_data);
            if (bus.write_stb) log_q.push_back({bus.write_act, bus.write_data});

            if (m_ch < 0) begin
                m_stb = 1'b0;
                if (bus.enable && bus.write_rdy != 2'b00) begin
                    m_ch      = bus.write_rdy[0] ? 0 : 1;
                    m_cap     = int'(bus.write_size);
                    m_fill    = 0;
                    m_idle    = 0;
                    m_closing = 1'b0;
                end
            end else if (m_closing) begin
                m_ch      = -1;
                m_stb     = 1'b0;
                m_closing = 1'b0;
            end else if (exp_rdy && bus.pixel_stb) begin
                m_stb  = 1'b1;
                m_data = {bus.red, bus.green, bus.blue};
                m_fill++;
                m_idle = 0;
                if (bus.pixel_last || m_fill == m_cap) m_closing = 1'b1;
            end else begin
                m_stb = 1'b0;
                if (m_fill > 0) begin
                    m_idle++;
                    if (T != 0 && m_idle == T) m_closing = 1'b1;
                end else if (m_cap == 0) begin
                    m_closing = 1'b1;
                end
            end
        end
    end

    task automatic set_pixel(input logic [23:0] px, input bit last, input bit stb);
        {bus.red, bus.green, bus.blue} = px;
        bus.pixel_last = last;
        bus.pixel_stb  = stb;
    endtask

    // Offers one pixel until the writer takes it; returns aligned just after the accepting edge.
    task automatic offer(input logic [23:0] px, input bit last);
        bit ok;
        ok = 1'b0;
        set_pixel(px, last, 1'b1);
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus.pixel_rdy) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        set_pixel(24'h0, 1'b0, 1'b0);
        check("offer_accepted", ok, 1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 300);
        check("wait_idle", bus.busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic activate(input logic [23:0] size, input logic [1:0] rdy);
        int t;
        bus.write_size = size;
        bus.write_rdy  = rdy;
        bus.enable     = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.busy && t < 50);
        check("activate", bus.busy, 1);
        @(posedge clk);
        #1;
        bus.write_rdy = 2'b00;
    endtask

    task automatic check_log(input string name, input int idx, input logic [1:0] act, input logic [23:0] data);
        check(name, (idx < log_q.size()) ? log_q[idx] : 26'h0, {act, data});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        int gap;
        checks   = 0;
        failures = 0;
        model_reset();
        rst_n          = 1'b0;
        bus.enable     = 1'b0;
        bus.write_rdy  = 2'b00;
        bus.write_size = '0;
        set_pixel(24'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_act", bus.write_act, 0);
        check("reset_pixel_rdy", bus.pixel_rdy, 0);

        // 1: basic fill of a 4-word buffer on channel 0
        log_q.delete();
        bus.write_size = 24'd4;
        bus.enable     = 1'b1;
        bus.write_rdy  = 2'b01;
        @(negedge clk);
        check("t1_act_before", bus.write_act, 2'b00);
        @(negedge clk);
        check("t1_act_after", bus.write_act, 2'b01);
        @(posedge clk);
        #1;
        bus.write_rdy = 2'b00;
        for (int i = 0; i < 4; i++) offer(24'h112233 + 24'(i) * 24'h111111, 1'b0);
        wait_idle(n);
        check("t1_release_latency", n, 2);
        check("t1_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) check_log("t1_word", i, 2'b01, 24'h112233 + 24'(i) * 24'h111111);

        // 2: ping-pong across both channels, FIFO clears a channel's ready once it is taken
        log_q.delete();
        bus.write_size = 24'd3;
        bus.write_rdy  = 2'b11;
        fork
            begin
                for (int i = 0; i < 6; i++) offer(24'hA00000 + 24'(i), 1'b0);
            end
            begin
                for (int t = 0; t < 100 && bus.write_act != 2'b01; t++) @(negedge clk);
                @(posedge clk);
                #1;
                bus.write_rdy = 2'b10;
                for (int t = 0; t < 100 && bus.write_act != 2'b10; t++) @(negedge clk);
                @(posedge clk);
                #1;
                bus.write_rdy = 2'b00;
            end
        join
        wait_idle(n);
        check("t2_count", log_q.size(), 6);
        for (int i = 0; i < 6; i++) check_log("t2_word", i, (i < 3) ? 2'b01 : 2'b10, 24'hA00000 + 24'(i));

        // 3: early release on the last pixel; the next pixel waits for a new buffer
        log_q.delete();
        activate(24'd8, 2'b01);
        offer(24'h300001, 1'b0);
        offer(24'h300002, 1'b0);
        offer(24'h300003, 1'b1);
        wait_idle(n);
        check("t3_count", log_q.size(), 3);
        set_pixel(24'h777777, 1'b0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("t3_held_rdy", bus.pixel_rdy, 0);
        end
        check("t3_held_count", log_q.size(), 3);
        @(posedge clk);
        #1;
        bus.write_rdy = 2'b01;
        offer(24'h777777, 1'b0);
        bus.write_rdy = 2'b00;
        offer(24'h888888, 1'b1);
        wait_idle(n);
        check("t3_total", log_q.size(), 5);
        check_log("t3_word", 3, 2'b01, 24'h777777);
        check_log("t3_word", 4, 2'b01, 24'h888888);

        // 4: idle flush, never while the buffer is still empty
        log_q.delete();
        activate(24'd16, 2'b01);
        repeat (30) @(negedge clk);
        check("t4_empty_no_timeout", bus.busy, 1);
        @(posedge clk);
        #1;
        offer(24'h400001, 1'b0);
        offer(24'h400002, 1'b0);
        wait_idle(n);
        check("t4_flush_latency", n, 12);
        check("t4_count", log_q.size(), 2);

        // 5: no buffer available, then a zero-size buffer
        log_q.delete();
        bus.write_rdy = 2'b00;
        set_pixel(24'h999999, 1'b0, 1'b1);
        repeat (10) begin
            @(negedge clk);
            check("t5_no_buf_rdy", bus.pixel_rdy, 0);
        end
        check("t5_no_buf_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        bus.write_size = 24'd0;
        bus.write_rdy  = 2'b01;
        hi = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (bus.busy) hi++;
            @(posedge clk);
            #1;
            if (t == 0) bus.write_rdy = 2'b00;
        end
        set_pixel(24'h0, 1'b0, 1'b0);
        check("t5_zero_act_cycles", hi, 2);
        check("t5_zero_count", log_q.size(), 0);

        // 6: asynchronous reset in the middle of a buffer, then a clean restart
        activate(24'd4, 2'b01);
        offer(24'h600001, 1'b0);
        offer(24'h600002, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_act", bus.write_act, 0);
        check("t6_async_stb", bus.write_stb, 0);
        check("t6_async_data", bus.write_data, 0);
        check("t6_async_rdy", bus.pixel_rdy, 0);
        check("t6_async_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        log_q.delete();
        activate(24'd4, 2'b01);
        for (int i = 0; i < 4; i++) offer(24'hC00000 + 24'(i), 1'b0);
        wait_idle(n);
        check("t6_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) check_log("t6_word", i, 2'b01, 24'hC00000 + 24'(i));

        // Random traffic, checked cycle by cycle against the model
        gap = 0;
        for (int c = 0; c < 1500; c++) begin
            bus.enable     = ($urandom_range(0, 9) != 0);
            bus.write_rdy  = 2'($urandom_range(0, 3));
            bus.write_size = 24'($urandom_range(0, 6));
            if (gap > 0) begin
                gap--;
                set_pixel(24'h0, 1'b0, 1'b0);
            end else begin
                if ($urandom_range(0, 39) == 0) gap = $urandom_range(8, 14);
                set_pixel(24'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
            end
            @(posedge clk);
            #1;
        end
        bus.write_rdy = 2'b00;
        set_pixel(24'h0, 1'b0, 1'b0);
        wait_idle(n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
